// File: rtl/shift_distance_tracker_pkg.sv
// Shared types and helpers for the shift-distance normalizer and the
// leading-sign-count encoder.
package shift_distance_tracker_pkg;

    localparam int DIST_W = 8;

    typedef logic [DIST_W-1:0] dist_t;

    function automatic int calc_max_dist(input int in_width, input int out_width);
        return in_width - out_width;
    endfunction

    function automatic int calc_lsc_width(input int in_width);
        return $clog2(in_width);
    endfunction

    // Largest safe shift from a window minimum: subtract the margin, floor at 0,
    // clamp to the widest shift the slice stage can take.
    function automatic int calc_cand(input int min_lsc, input int headroom, input int max_dist);
        int c;
        c = min_lsc - headroom;
        if (c < 0) begin
            c = 0;
        end
        if (c > max_dist) begin
            c = max_dist;
        end
        return c;
    endfunction

endpackage

// File: rtl/leading_sign_count.sv
// Priority encoder: number of bits directly below the MSB that equal the MSB
// (0..IN_WIDTH-1). All-zero and all-ones inputs give IN_WIDTH-1.
module leading_sign_count #(
    parameter int IN_WIDTH = 88,
    localparam int CNT_W = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] sample_i,
    output logic [CNT_W-1:0]    count_o
);

    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int i = IN_WIDTH - 2; i >= 0; i--) begin
            if (run && (sample_i[i] == sample_i[IN_WIDTH-1])) begin
                count_o = count_o + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_distance_tracker.sv
// Automatic normalizer: tracks the minimum redundant-sign count per window and
// moves the slice shift distance with fast attack and held, +1-per-step decay.
module shift_distance_tracker
    import shift_distance_tracker_pkg::*;
#(
    parameter int IN_WIDTH     = 88,
    parameter int OUT_WIDTH    = 32,
    parameter int WINDOW_LOG2  = 10,
    parameter int HEADROOM     = 1,
    parameter int HOLD_WINDOWS = 4
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic [IN_WIDTH-1:0] data_in,
    input  logic                data_valid,
    input  logic                enable,
    input  logic [7:0]          manual_distance,
    output logic [7:0]          distance,
    output logic                distance_valid,
    output logic                overflow_flag
);

    localparam int MAX_DIST = calc_max_dist(IN_WIDTH, OUT_WIDTH);
    localparam int LSC_W    = calc_lsc_width(IN_WIDTH);
    localparam int HOLD_W   = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;

    localparam dist_t                  MAX_DIST_D = dist_t'(MAX_DIST);
    localparam logic [LSC_W-1:0]       LSC_RESET  = LSC_W'(IN_WIDTH - 1);
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST   = WINDOW_LOG2'((2 ** WINDOW_LOG2) - 1);
    localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HOLD_WINDOWS - 1);

    // Stage 1: registered sample.
    logic [IN_WIDTH-1:0]    data_q;
    logic                   valid_q, valid_d;

    // Stage 2: window and tracking state.
    logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [LSC_W-1:0]       min_lsc_q, min_lsc_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    dist_t                  distance_q, distance_d;
    logic                   dist_valid_q, dist_valid_d;
    logic                   overflow_q, overflow_d;

    logic [LSC_W-1:0]       lsc;
    logic [LSC_W-1:0]       min_now;
    logic                   ovf_now;
    logic                   window_end;
    dist_t                  cand;
    dist_t                  manual_clamped;

    leading_sign_count #(
        .IN_WIDTH(IN_WIDTH)
    ) u_lsc (
        .sample_i(data_q),
        .count_o (lsc)
    );

    // Only samples seen while tracking is enabled may enter a window.
    assign valid_d = data_valid & enable;

    always_comb begin
        manual_clamped = (manual_distance > MAX_DIST_D) ? MAX_DIST_D : manual_distance;
        min_now        = (lsc < min_lsc_q) ? lsc : min_lsc_q;
        ovf_now        = ovf_acc_q | (int'(lsc) < int'(distance_q));
        cand           = dist_t'(calc_cand(int'(min_now), HEADROOM, MAX_DIST));
        window_end     = valid_q && (win_cnt_q == WIN_LAST);

        win_cnt_d    = win_cnt_q;
        min_lsc_d    = min_lsc_q;
        ovf_acc_d    = ovf_acc_q;
        hold_d       = hold_q;
        distance_d   = distance_q;
        dist_valid_d = 1'b0;
        overflow_d   = overflow_q;

        if (!enable) begin
            // Manual mode: any partial window is dropped, overflow_flag keeps its value.
            win_cnt_d    = '0;
            min_lsc_d    = LSC_RESET;
            ovf_acc_d    = 1'b0;
            hold_d       = '0;
            distance_d   = manual_clamped;
            dist_valid_d = (manual_clamped != distance_q);
        end else if (window_end) begin
            win_cnt_d    = '0;
            min_lsc_d    = LSC_RESET;
            ovf_acc_d    = 1'b0;
            overflow_d   = ovf_now;
            dist_valid_d = 1'b1;
            if (cand < distance_q) begin
                distance_d = cand;
                hold_d     = '0;
            end else if (cand > distance_q) begin
                if (hold_q == HOLD_LAST) begin
                    distance_d = distance_q + dist_t'(1);
                    hold_d     = '0;
                end else begin
                    hold_d     = hold_q + HOLD_W'(1);
                end
            end else begin
                hold_d = '0;
            end
        end else if (valid_q) begin
            win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
            min_lsc_d = min_now;
            ovf_acc_d = ovf_now;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            win_cnt_q    <= '0;
            min_lsc_q    <= LSC_RESET;
            ovf_acc_q    <= 1'b0;
            hold_q       <= '0;
            distance_q   <= '0;
            dist_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            data_q       <= data_in;
            valid_q      <= valid_d;
            win_cnt_q    <= win_cnt_d;
            min_lsc_q    <= min_lsc_d;
            ovf_acc_q    <= ovf_acc_d;
            hold_q       <= hold_d;
            distance_q   <= distance_d;
            dist_valid_q <= dist_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign distance       = distance_q;
    assign distance_valid = dist_valid_q;
    assign overflow_flag  = overflow_q;

endmodule
